gemm_result_drain: RTL and testbench
====================================

Name: gemm_result_drain

Overview:
- Read-side counterpart of the tau_mac GEMM array.
- Snapshots the DIM x DIM accumulator matrix when the array pulses its finished signal, then streams the matrix out one row per beat over a valid/ready interface to the downstream writeback/DMA.
- Frees the array to start the next GEMM while the previous result drains.

Parameters:
- DIM, 16, matrix dimension: rows streamed per result, elements per row.
- OUT_BITS, 16, width of one accumulator element (2 x operand WIDTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- mac_out  input  DIM*DIM*OUT_BITS  packed [DIM][DIM][OUT_BITS] result matrix from the MAC array, [row][col].
- capture  input  1  single-cycle pulse: mac_out is final this cycle (driven by the array's finished).
- row_data  output  DIM*OUT_BITS  packed [DIM][OUT_BITS]: current row of the snapshot.
- row_idx  output  IDX_W  index of the row on row_data; IDX_W = max(1, $clog2(DIM)).
- row_valid  output  1  row_data/row_idx/row_last are valid.
- row_ready  input  1  downstream accepts the row this cycle.
- row_last  output  1  high with row_valid when row_idx == DIM-1.
- busy  output  1  high while a snapshot is held and not fully drained.
- overrun  output  1  sticky: a capture was dropped because a drain was in progress.
- clear_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; row_valid=0, row_last=0, busy=0, overrun=0, row_idx=0.
  - Snapshot register need not be reset; row_data is don't-care while row_valid=0.
- States: IDLE, DRAIN.
- IDLE:
  - capture=1: latch full mac_out into snapshot, row_idx<=0, go to DRAIN.
  - First row_valid appears the cycle after capture (latency 1).
- DRAIN:
  - row_valid=1, busy=1; row_data = snapshot[row_idx].
  - Transfer occurs when row_valid && row_ready.
  - Transfer with row_idx<DIM-1: row_idx<=row_idx+1.
  - Transfer with row_idx==DIM-1 (row_last): return to IDLE, row_valid=0 next cycle, busy=0, unless a capture arrives in the same cycle (see below).
  - No transfer: row_data, row_idx, row_last held stable; row_valid never drops without a transfer.
- Capture during DRAIN, not on the last transfer: ignored; snapshot unchanged; overrun<=1.
- Capture in the same cycle as the last-row transfer: accepted back-to-back; snapshot reloaded, row_idx<=0, stay in DRAIN; no overrun; no bubble between row DIM-1 and new row 0.
- overrun is sticky until clear_overrun=1. If clear_overrun and a new overrun event occur in the same cycle, set wins.
- row_ready while row_valid=0 has no effect.
- Throughput: 1 row/cycle with row_ready held high; full drain = DIM cycles after the first valid.
- Reset mid-drain: immediately returns to IDLE with outputs at reset values; the partial drain is abandoned and is not resumed.
- DIM=1: row_idx is constant 0 and row_last=row_valid.

Decomposition:
- gemm_pkg:
  - default DIM/WIDTH/OUT_BITS constants;
  - drain_state_t enum {IDLE, DRAIN};
  - IDX_W helper function.
- Single module. The snapshot register and row mux stay inline; no sub-module is warranted.

Test Plan:
- DIM=4, OUT_BITS=16, mac_out[r][c]=16'h0100*r+c, capture pulse, row_ready=1 -> rows 0..3 on cycles 1..4; row 2 data {0x0203,0x0202,0x0201,0x0200}; row_last only on row 3; busy low on cycle 5.
- Same capture, row_ready toggled 1,0,0,1,1,0,1 -> each row held stable while stalled; all 4 rows delivered exactly once, in order; row_valid never drops mid-drain.
- Second capture with different mac_out (all 0xFFFF) at row_idx=1 -> stream continues with original values; overrun=1 and stays 1; clear_overrun pulse -> overrun=0 next cycle.
- Second capture in the same cycle as the row-3 transfer -> next cycle row_idx=0 with 0xFFFF data, no idle cycle, overrun=0.
- Assert reset_n=0 at row_idx=2 for 1 cycle -> row_valid, busy, row_last drop asynchronously; after release stays IDLE until the next capture, then restarts at row 0.
- Randomized ready backpressure plus mac_out changing every cycle after capture -> scoreboard shows streamed data equals the value sampled at capture, never a later mac_out.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared constants, types and helpers for the GEMM result drain.
package gemm_pkg;

  localparam int DEFAULT_DIM      = 16;
  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_OUT_BITS = 2 * DEFAULT_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Row index width; a single-row matrix still needs a 1-bit index port.
  function automatic int idx_w(input int dim);
    return (dim <= 1) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/gemm_result_drain.sv
// Snapshots the MAC array result on capture and streams it out one row per
// valid/ready beat, so the array can start the next GEMM immediately.
module gemm_result_drain
  import gemm_pkg::*;
#(
  parameter int DIM = DEFAULT_DIM,
  parameter int OUT_BITS = DEFAULT_OUT_BITS,
  localparam int IDX_W = idx_w(DIM)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0]  mac_out,
  input  logic                                   capture,
  output logic [DIM-1:0][OUT_BITS-1:0]           row_data,
  output logic [IDX_W-1:0]                       row_idx,
  output logic                                   row_valid,
  input  logic                                   row_ready,
  output logic                                   row_last,
  output logic                                   busy,
  output logic                                   overrun,
  input  logic                                   clear_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  drain_state_t                          state_reg;
  logic [IDX_W-1:0]                      idx_reg;
  logic                                  valid_reg;
  logic                                  last_reg;
  logic                                  busy_reg;
  logic                                  overrun_reg;
  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] snap_reg;

  logic xfer;
  logic at_last;
  logic load;
  logic drop;

  assign xfer    = valid_reg && row_ready;
  assign at_last = (idx_reg == LAST_IDX);
  // A capture coinciding with the final beat chains straight into the next drain.
  assign load    = capture && ((state_reg == IDLE) || (xfer && at_last));
  assign drop    = capture && (state_reg == DRAIN) && !(xfer && at_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (clear_overrun) begin
        overrun_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (capture) begin
            state_reg <= DRAIN;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            last_reg  <= (DIM == 1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (at_last) begin
              idx_reg <= '0;
              if (capture) begin
                last_reg <= (DIM == 1);
              end else begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
                busy_reg  <= 1'b0;
                last_reg  <= 1'b0;
              end
            end else begin
              idx_reg  <= idx_reg + 1'b1;
              last_reg <= ((idx_reg + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Snapshot holds data only; its contents are meaningless until the first load.
  always_ff @(posedge clk) begin
    if (load) begin
      snap_reg <= mac_out;
    end
  end

  generate
    if (DIM == 1) begin : g_single_row
      assign row_data = snap_reg[0];
    end else begin : g_row_mux
      assign row_data = snap_reg[idx_reg];
    end
  endgenerate

  assign row_idx   = idx_reg;
  assign row_valid = valid_reg;
  assign row_last  = last_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_gemm_result_drain.sv
// Scenario bench for gemm_result_drain with a row scoreboard fed at capture time.
module tb_gemm_result_drain;
  import gemm_pkg::*;

  localparam int DIM = 4;
  localparam int OUT_BITS = 16;
  localparam int IDX_W = idx_w(DIM);

  typedef logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] mat_t;
  typedef logic [DIM-1:0][OUT_BITS-1:0] row_t;
  typedef struct {
    logic [IDX_W-1:0] idx;
    row_t             data;
    logic             last;
  } exp_t;

  logic             clk;
  logic             reset_n;
  mat_t             mac_out;
  logic             capture;
  row_t             row_data;
  logic [IDX_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;
  logic             busy;
  logic             overrun;
  logic             clear_overrun;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  gemm_result_drain #(.DIM(DIM), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk), .reset_n(reset_n), .mac_out(mac_out), .capture(capture),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .row_ready(row_ready), .row_last(row_last), .busy(busy),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples on the falling edge what the next rising edge will see.
  logic             prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx;
  row_t             prev_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (row_valid !== 1'b1 || row_idx !== prev_idx || row_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                   row_valid, row_idx, row_data, prev_idx, prev_data);
        end
      end
      if (row_valid === 1'b1 && row_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: idx=%0d data=%h required no beat", row_idx, row_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (row_idx !== e.idx || row_data !== e.data || row_last !== e.last) begin
            bad++;
            $display("FAIL beat: idx=%0d data=%h last=%0b required idx=%0d data=%h last=%0b",
                     row_idx, row_data, row_last, e.idx, e.data, e.last);
          end else begin
            $display("beat idx=%0d data=%h last=%0b", row_idx, row_data, row_last);
          end
        end
      end
      prev_stall = row_valid && !row_ready;
      prev_idx   = row_idx;
      prev_data  = row_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t pattern_mat();
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 16'(16'h0100 * r + c);
    return m;
  endfunction

  function automatic mat_t const_mat(input logic [OUT_BITS-1:0] v);
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = v;
    return m;
  endfunction

  function automatic mat_t random_mat();
    mat_t m;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 16'($urandom);
    return m;
  endfunction

  task automatic push_rows(input mat_t m);
    exp_t e;
    for (int r = 0; r < DIM; r++) begin
      e.idx  = IDX_W'(r);
      e.data = m[r];
      e.last = (r == DIM - 1);
      sb.push_back(e);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((sb.size() != 0 || row_valid !== 1'b0) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d valid=%0b required pending=0 valid=0",
               name, sb.size(), row_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; capture = 1'b0; row_ready = 1'b0; clear_overrun = 1'b0;
    mac_out = '0;
    repeat (3) tick();
    check_bit("reset_valid", row_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_last", row_last, 1'b0);
    check_bit("reset_overrun", overrun, 1'b0);
    total++;
    if (row_idx !== '0) begin
      bad++;
      $display("FAIL reset_idx: got %0d required 0", row_idx);
    end
    reset_n = 1'b1;
    tick();
    check_bit("idle_after_reset", row_valid, 1'b0);
  endtask

  task automatic test_basic_stream();
    row_t r2;
    r2 = 64'h0203_0202_0201_0200;
    row_ready = 1'b1;
    mac_out = pattern_mat();
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    for (int cyc = 1; cyc <= DIM; cyc++) begin
      check_bit("basic_valid", row_valid, 1'b1);
      check_bit("basic_busy", busy, 1'b1);
      total++;
      if (row_idx !== IDX_W'(cyc - 1)) begin
        bad++;
        $display("FAIL basic_idx: got %0d required %0d", row_idx, cyc - 1);
      end
      if (cyc == 3) begin
        total++;
        if (row_data !== r2) begin
          bad++;
          $display("FAIL basic_row2: got %h required %h", row_data, r2);
        end
      end
      tick();
    end
    check_bit("basic_busy_done", busy, 1'b0);
    check_bit("basic_valid_done", row_valid, 1'b0);
    row_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [6:0] pat;
    pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    mac_out = pattern_mat();
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_bit("bp_valid", row_valid, 1'b1);
      row_ready = pat[i];
      tick();
    end
    row_ready = 1'b0;
    check_bit("bp_valid_done", row_valid, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL bp_pending: got %0d required 0", sb.size());
    end
  endtask

  task automatic test_overrun();
    row_ready = 1'b1;
    mac_out = pattern_mat();
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    tick();  // row_idx now 1
    mac_out = const_mat(16'hFFFF);
    capture = 1'b1;
    tick();  // row_idx now 2
    check_bit("ovr_set", overrun, 1'b1);
    clear_overrun = 1'b1;  // new drop in the same cycle must win
    tick();
    capture = 1'b0;
    clear_overrun = 1'b0;
    check_bit("ovr_set_wins", overrun, 1'b1);
    wait_drained("ovr_drain");
    check_bit("ovr_sticky", overrun, 1'b1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check_bit("ovr_cleared", overrun, 1'b0);
    row_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_ready = 1'b1;
    mac_out = pattern_mat();
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    repeat (DIM - 1) tick();  // row_idx now DIM-1
    check_bit("b2b_at_last", row_last, 1'b1);
    mac_out = const_mat(16'hFFFF);
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    check_bit("b2b_no_bubble", row_valid, 1'b1);
    check_bit("b2b_no_overrun", overrun, 1'b0);
    total++;
    if (row_idx !== '0) begin
      bad++;
      $display("FAIL b2b_idx: got %0d required 0", row_idx);
    end
    wait_drained("b2b_drain");
    row_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    row_ready = 1'b1;
    mac_out = pattern_mat();
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    tick();
    tick();  // row_idx now 2
    reset_n = 1'b0;
    #1;
    check_bit("rst_mid_valid", row_valid, 1'b0);
    check_bit("rst_mid_busy", busy, 1'b0);
    check_bit("rst_mid_last", row_last, 1'b0);
    sb.delete();  // abandoned rows are never delivered
    tick();
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      check_bit("rst_stays_idle", row_valid, 1'b0);
    end
    mac_out = const_mat(16'h1234);
    capture = 1'b1;
    push_rows(mac_out);
    tick();
    capture = 1'b0;
    total++;
    if (row_valid !== 1'b1 || row_idx !== '0) begin
      bad++;
      $display("FAIL rst_restart: valid=%0b idx=%0d required valid=1 idx=0", row_valid, row_idx);
    end
    wait_drained("rst_drain");
    row_ready = 1'b0;
  endtask

  task automatic test_random_backpressure();
    for (int it = 0; it < 4; it++) begin
      mac_out = random_mat();
      capture = 1'b1;
      push_rows(mac_out);
      row_ready = 1'($urandom_range(0, 1));
      tick();
      capture = 1'b0;
      for (int n = 0; n < 200 && (sb.size() != 0 || row_valid); n++) begin
        mac_out = random_mat();
        row_ready = 1'($urandom_range(0, 1));
        tick();
      end
      row_ready = 1'b0;
      total++;
      if (sb.size() != 0 || row_valid !== 1'b0) begin
        bad++;
        $display("FAIL rand_timeout: pending=%0d valid=%0b required pending=0 valid=0",
                 sb.size(), row_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid_drain();
    test_random_backpressure();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
